noise_sample_sched: RTL and testbench

//  Round-robin scheduler that shares the single noise RNG between noise-polynomial requesters
//  (secret s, errors e1/e2). The granted requester receives COEFFS coefficients in order.

---
 rtl/noise_sample_sched_if.sv | 33 +++
 rtl/noise_sample_sched.sv | 140 ++++++++++++++
 tb/tb_noise_sample_sched.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noise_sample_sched_if.sv
// Signal bundle between the noise sample scheduler, the shared RNG, the requesters
// and the coefficient consumer. master = scheduler side, slave = environment side.
interface noise_sample_sched_if #(
    parameter int NUM_REQ = 3,
    parameter int COEFFS  = 4,
    parameter int RNG_W   = 6,
    parameter int IDX_W   = (COEFFS > 1) ? $clog2(COEFFS) : 1
);
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ-1:0]      grant;
    logic [NUM_REQ-1:0]      done;
    logic                    rng_enable;
    logic signed [RNG_W-1:0] rng_value;
    logic                    coeff_valid;
    logic                    coeff_ready;
    logic signed [RNG_W-1:0] coeff_data;
    logic [IDX_W-1:0]        coeff_idx;
    logic                    coeff_last;
    logic [7:0]              reject_cnt;
    logic                    busy;

    modport master (
        input  req, rng_value, coeff_ready,
        output grant, done, rng_enable, coeff_valid, coeff_data,
               coeff_idx, coeff_last, reject_cnt, busy
    );

    modport slave (
        output req, rng_value, coeff_ready,
        input  grant, done, rng_enable, coeff_valid, coeff_data,
               coeff_idx, coeff_last, reject_cnt, busy
    );
endinterface

// File: rtl/noise_sample_sched.sv
// Round-robin owner of the shared noise RNG: draws COEFFS samples per grant, rejects
// samples outside [-ETA,+ETA] and streams the accepted ones out on valid/ready.
module noise_sample_sched #(
    parameter int NUM_REQ = 3,
    parameter int COEFFS  = 4,
    parameter int ETA     = 17,
    parameter int RNG_W   = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    noise_sample_sched_if.master bus
);
    localparam int IDX_W = (COEFFS > 1) ? $clog2(COEFFS) : 1;
    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic signed [RNG_W-1:0] ETA_HI   = RNG_W'(ETA);
    localparam logic signed [RNG_W-1:0] ETA_LO   = RNG_W'(-ETA);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(COEFFS - 1);
    localparam logic [PTR_W-1:0]        LAST_PTR = PTR_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CHECK,
        S_SEND,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]        owner_q, owner_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [RNG_W-1:0] data_q, data_d;
    logic [7:0]              rej_q, rej_d;

    logic                    pick_found;
    logic [PTR_W-1:0]        pick_idx;
    logic [PTR_W-1:0]        cand;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    // First requester found when scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        cand       = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(rr_ptr_q, k);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        data_d   = data_q;
        rej_d    = rej_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    owner_d           = pick_idx;
                    idx_d             = '0;
                    state_d           = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_CHECK;
            S_CHECK: begin
                if (bus.rng_value >= ETA_LO && bus.rng_value <= ETA_HI) begin
                    data_d  = bus.rng_value;
                    state_d = S_SEND;
                end else begin
                    if (rej_q != 8'hFF) rej_d = rej_q + 8'd1;
                    state_d = S_ISSUE;
                end
            end
            S_SEND: begin
                if (bus.coeff_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                grant_d  = '0;
                rr_ptr_d = (owner_q == LAST_PTR) ? '0 : owner_q + PTR_W'(1);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            rej_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            rej_q    <= rej_d;
        end
    end

    // Outputs are pure decodes of registered state, so reset clears them asynchronously.
    assign bus.grant       = grant_q;
    assign bus.done        = (state_q == S_DONE) ? grant_q : '0;
    assign bus.rng_enable  = (state_q == S_ISSUE);
    assign bus.coeff_valid = (state_q == S_SEND);
    assign bus.coeff_data  = data_q;
    assign bus.coeff_idx   = idx_q;
    assign bus.coeff_last  = (state_q == S_SEND) && (idx_q == LAST_IDX);
    assign bus.reject_cnt  = rej_q;
    assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_noise_sample_sched.sv
// Self-checking bench for noise_sample_sched: scripted and random RNG draws are
// compared against a filtered-draw / round-robin reference model.
module tb_noise_sample_sched;
    localparam int NUM_REQ = 3;
    localparam int COEFFS  = 4;
    localparam int ETA     = 17;
    localparam int RNG_W   = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    noise_sample_sched_if #(.NUM_REQ(NUM_REQ), .COEFFS(COEFFS), .RNG_W(RNG_W)) sif ();

    noise_sample_sched #(.NUM_REQ(NUM_REQ), .COEFFS(COEFFS), .ETA(ETA), .RNG_W(RNG_W)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (sif)
    );

    int checks = 0;
    int errors = 0;

    // RNG model: scripted values first, otherwise random; reject_mode forces out-of-range draws.
    logic signed [RNG_W-1:0] rng_script[256];
    int rng_wr = 0;
    int rng_rd = 0;
    bit reject_mode = 1'b0;

    function automatic logic signed [RNG_W-1:0] oor_value();
        int v;
        v = $urandom_range(31, ETA + 1);
        if ($urandom_range(1, 0) == 1) v = -v - int'($urandom_range(1, 0));
        return RNG_W'(v);
    endfunction

    always @(posedge clk) begin
        if (rst_n && sif.rng_enable) begin
            if (reject_mode) sif.rng_value <= oor_value();
            else if (rng_rd < rng_wr) begin
                sif.rng_value <= rng_script[rng_rd % 256];
                rng_rd <= rng_rd + 1;
            end else sif.rng_value <= RNG_W'($urandom);
        end
    end

    // Monitor: records every draw, accepted beat and done pulse.
    int cyc = 0;
    int rng_pulses = 0;
    bit en_prev = 1'b0;
    logic signed [RNG_W-1:0] drawn[$];
    logic signed [RNG_W-1:0] mon_data[$];
    int mon_idx[$];
    bit mon_last[$];
    int mon_cyc[$];
    int mon_pulses[$];
    logic [NUM_REQ-1:0] mon_done[$];

    always @(negedge clk) begin
        cyc++;
        if (en_prev) drawn.push_back(sif.rng_value);
        en_prev = sif.rng_enable;
        if (sif.rng_enable) rng_pulses++;
        if (sif.coeff_valid && sif.coeff_ready) begin
            mon_data.push_back(sif.coeff_data);
            mon_idx.push_back(int'(sif.coeff_idx));
            mon_last.push_back(sif.coeff_last);
            mon_cyc.push_back(cyc);
            mon_pulses.push_back(rng_pulses);
        end
        if (sif.done != '0) mon_done.push_back(sif.done);
    end

    int rej_base = 0;

    function automatic int model_rejects();
        int n = 0;
        for (int i = rej_base; i < drawn.size(); i++)
            if (drawn[i] < -ETA || drawn[i] > ETA) n++;
        return (n > 255) ? 255 : n;
    endfunction

    function automatic int accepted_at(int from, int nth);
        int seen = 0;
        for (int i = from; i < drawn.size(); i++) begin
            if (drawn[i] >= -ETA && drawn[i] <= ETA) begin
                if (seen == nth) return int'(drawn[i]);
                seen++;
            end
        end
        return 999;
    endfunction

    function automatic logic [25:0] outs_word();
        return {sif.grant, sif.done, sif.rng_enable, sif.coeff_valid, sif.coeff_data,
                sif.coeff_idx, sif.coeff_last, sif.reject_cnt, sif.busy};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_rng(input int v);
        rng_script[rng_wr % 256] = RNG_W'(v);
        rng_wr++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sif.req = '0;
        sif.coeff_ready = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        rej_base = drawn.size();
    endtask

    task automatic wait_done(input int start, input int limit, input bit rand_ready, input string name);
        int n = 0;
        while (mon_done.size() <= start && n < limit) begin
            if (rand_ready) sif.coeff_ready = 1'($urandom_range(1, 0));
            tick(1);
            n++;
        end
        checks++;
        if (mon_done.size() <= start) begin
            errors++;
            $display("[TB] FAIL %s: no done pulse within %0d cycles (got %0d pulses, need 1)",
                     name, limit, mon_done.size() - start);
        end
    endtask

    task automatic test_reset();
        sif.req = '0;
        sif.coeff_ready = 1'b0;
        rst_n = 1'b0;
        tick(2);
        checks++;
        if (outs_word() !== 26'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0", outs_word());
        end
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (outs_word() !== 26'd0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got %h, expected 0", outs_word());
        end
        rej_base = drawn.size();
    endtask

    task automatic test_basic();
        int b0 = mon_data.size();
        int d0 = mon_done.size();
        int p0 = rng_pulses;
        int exp_d[4] = '{5, -3, 0, 17};
        foreach (exp_d[i]) push_rng(exp_d[i]);
        sif.coeff_ready = 1'b1;
        sif.req = 3'b001;
        tick(1);
        checks++;
        if (sif.grant !== 3'b001) begin
            errors++;
            $display("[TB] FAIL basic_grant: got %b, expected 001", sif.grant);
        end
        wait_done(d0, 60, 1'b0, "basic_done");
        sif.req = '0;
        tick(1);
        checks++;
        if (mon_data.size() - b0 != 4) begin
            errors++;
            $display("[TB] FAIL basic_beats: got %0d, expected 4", mon_data.size() - b0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (int'(mon_data[b0+i]) != exp_d[i] || mon_idx[b0+i] != i || mon_last[b0+i] != (i == 3)) begin
                    errors++;
                    $display("[TB] FAIL basic_beat%0d: got data %0d idx %0d last %0d, expected %0d %0d %0d",
                             i, mon_data[b0+i], mon_idx[b0+i], mon_last[b0+i], exp_d[i], i, i == 3);
                end
            end
            checks++;
            if (mon_cyc[b0+1] - mon_cyc[b0] != 3) begin
                errors++;
                $display("[TB] FAIL basic_latency: got %0d cycles, expected 3", mon_cyc[b0+1] - mon_cyc[b0]);
            end
        end
        checks++;
        if (mon_done.size() - d0 != 1 || mon_done[d0] !== 3'b001) begin
            errors++;
            $display("[TB] FAIL basic_done_pulse: got %0d cycles value %b, expected 1 cycle 001",
                     mon_done.size() - d0, mon_done[d0]);
        end
        checks++;
        if (rng_pulses - p0 != 4 || sif.grant !== 3'b000 || sif.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_after: got pulses %0d grant %b busy %b, expected 4 000 0",
                     rng_pulses - p0, sif.grant, sif.busy);
        end
    endtask

    task automatic test_reject();
        int b0 = mon_data.size();
        int d0 = mon_done.size();
        int p0 = rng_pulses;
        int exp_d[4] = '{-17, 1, 2, 3};
        push_rng(20); push_rng(-18); push_rng(-17);
        push_rng(1);  push_rng(2);   push_rng(3);
        sif.coeff_ready = 1'b1;
        sif.req = 3'b001;
        tick(1);
        sif.req = '0;
        wait_done(d0, 60, 1'b0, "reject_done");
        checks++;
        if (mon_data.size() - b0 != 4) begin
            errors++;
            $display("[TB] FAIL reject_beats: got %0d, expected 4", mon_data.size() - b0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (int'(mon_data[b0+i]) != exp_d[i] || mon_idx[b0+i] != i) begin
                    errors++;
                    $display("[TB] FAIL reject_beat%0d: got %0d idx %0d, expected %0d idx %0d",
                             i, mon_data[b0+i], mon_idx[b0+i], exp_d[i], i);
                end
            end
            checks++;
            if (mon_pulses[b0] - p0 != 3) begin
                errors++;
                $display("[TB] FAIL reject_pulses_first: got %0d, expected 3", mon_pulses[b0] - p0);
            end
        end
        checks++;
        if (int'(sif.reject_cnt) != model_rejects() || model_rejects() != 2) begin
            errors++;
            $display("[TB] FAIL reject_cnt: got %0d, expected %0d (model) and 2", sif.reject_cnt, model_rejects());
        end
    endtask

    task automatic test_stall();
        int b0 = mon_data.size();
        int d0 = mon_done.size();
        int n = 0;
        int exp_d[4] = '{7, -7, 9, -9};
        foreach (exp_d[i]) push_rng(exp_d[i]);
        sif.coeff_ready = 1'b0;
        sif.req = 3'b001;
        tick(1);
        sif.req = '0;
        while (!sif.coeff_valid && n < 20) begin
            tick(1);
            n++;
        end
        checks++;
        if (sif.coeff_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_valid: got %b, expected 1", sif.coeff_valid);
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (sif.coeff_valid !== 1'b1 || int'(sif.coeff_data) != 7 || sif.coeff_idx !== 2'd0 || sif.rng_enable !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: got valid %b data %0d idx %0d en %b, expected 1 7 0 0",
                         c, sif.coeff_valid, sif.coeff_data, sif.coeff_idx, sif.rng_enable);
            end
            tick(1);
        end
        checks++;
        if (mon_data.size() != b0) begin
            errors++;
            $display("[TB] FAIL stall_nobeat: got %0d beats, expected 0", mon_data.size() - b0);
        end
        sif.coeff_ready = 1'b1;
        wait_done(d0, 60, 1'b0, "stall_done");
        checks++;
        if (mon_data.size() - b0 != 4 || int'(mon_data[b0]) != 7 || int'(mon_data[b0+3]) != -9) begin
            errors++;
            $display("[TB] FAIL stall_beats: got %0d beats first %0d last %0d, expected 4 7 -9",
                     mon_data.size() - b0, mon_data[b0], mon_data[mon_data.size()-1]);
        end
    endtask

    task automatic test_req_drop();
        int b0 = mon_data.size();
        int d0 = mon_done.size();
        int n = 0;
        int bad = 0;
        sif.coeff_ready = 1'b1;
        sif.req = 3'b001;
        while (mon_data.size() < b0 + 2 && n < 40) begin
            tick(1);
            n++;
        end
        sif.req = '0;
        n = 0;
        while (mon_done.size() <= d0 && n < 60) begin
            if (sif.grant !== 3'b001) bad++;
            tick(1);
            n++;
        end
        checks++;
        if (bad != 0 || mon_done.size() <= d0) begin
            errors++;
            $display("[TB] FAIL reqdrop_grant: got %0d cycles without grant 001, done seen %0d, expected 0 and 1",
                     bad, mon_done.size() - d0);
        end
        checks++;
        if (mon_data.size() - b0 != 4 || mon_done[d0] !== 3'b001) begin
            errors++;
            $display("[TB] FAIL reqdrop_burst: got %0d beats done %b, expected 4 001",
                     mon_data.size() - b0, mon_done[d0]);
        end
    endtask

    task automatic test_round_robin();
        int d0;
        logic [NUM_REQ-1:0] exp_g[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        do_reset();
        d0 = mon_done.size();
        sif.coeff_ready = 1'b1;
        sif.req = 3'b011;
        for (int b = 0; b < 4; b++) begin
            wait_done(d0 + b, 80, 1'b0, "rr_done");
            checks++;
            if (mon_done[d0+b] !== exp_g[b] || sif.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rr_order%0d: got done %b busy %b, expected %b 0",
                         b, mon_done[d0+b], sif.busy, exp_g[b]);
            end
            if (b == 1) sif.req = 3'b101;
        end
        sif.req = '0;
        tick(1);
    endtask

    task automatic test_reset_mid();
        int b0;
        int d0;
        int n = 0;
        do_reset();
        sif.coeff_ready = 1'b1;
        sif.req = 3'b010;
        d0 = mon_done.size();
        wait_done(d0, 80, 1'b0, "mid_prep");
        sif.req = 3'b100;
        b0 = mon_data.size();
        while (mon_data.size() < b0 + 2 && n < 80) begin
            tick(1);
            n++;
        end
        sif.coeff_ready = 1'b0;
        sif.req = '0;
        n = 0;
        while (!(sif.coeff_valid && sif.coeff_idx == 2'd2) && n < 80) begin
            tick(1);
            n++;
        end
        checks++;
        if (!(sif.coeff_valid === 1'b1 && sif.coeff_idx === 2'd2)) begin
            errors++;
            $display("[TB] FAIL mid_reach: got valid %b idx %0d, expected 1 2", sif.coeff_valid, sif.coeff_idx);
        end
        d0 = mon_done.size();
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs_word() !== 26'd0) begin
            errors++;
            $display("[TB] FAIL mid_async_clear: got %h, expected 0", outs_word());
        end
        tick(2);
        rst_n = 1'b1;
        rej_base = drawn.size();
        tick(1);
        checks++;
        if (sif.busy !== 1'b0 || mon_done.size() != d0) begin
            errors++;
            $display("[TB] FAIL mid_after: got busy %b done pulses %0d, expected 0 0", sif.busy, mon_done.size() - d0);
        end
        sif.coeff_ready = 1'b1;
        sif.req = 3'b110;
        tick(1);
        checks++;
        if (sif.grant !== 3'b010) begin
            errors++;
            $display("[TB] FAIL mid_rrptr: got grant %b, expected 010", sif.grant);
        end
        sif.req = '0;
        wait_done(d0, 80, 1'b0, "mid_finish");
    endtask

    task automatic test_saturation();
        int b0;
        int d0;
        do_reset();
        b0 = mon_data.size();
        d0 = mon_done.size();
        reject_mode = 1'b1;
        sif.coeff_ready = 1'b1;
        sif.req = 3'b001;
        tick(1);
        sif.req = '0;
        tick(560);
        checks++;
        if (sif.reject_cnt !== 8'd255 || model_rejects() != 255 || mon_data.size() != b0 || sif.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_cnt: got cnt %0d beats %0d busy %b, expected 255 0 1",
                     sif.reject_cnt, mon_data.size() - b0, sif.busy);
        end
        reject_mode = 1'b0;
        wait_done(d0, 200, 1'b0, "sat_done");
        checks++;
        if (sif.reject_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL sat_hold: got %0d, expected 255", sif.reject_cnt);
        end
    endtask

    task automatic test_random();
        int exp_rr = 0;
        do_reset();
        for (int b = 0; b < 8; b++) begin
            int b0 = mon_data.size();
            int d0 = mon_done.size();
            int dr0 = drawn.size();
            int w = -1;
            logic [NUM_REQ-1:0] r;
            r = 3'($urandom_range(7, 1));
            for (int k = 0; k < NUM_REQ; k++) begin
                int c = (exp_rr + k) % NUM_REQ;
                if (w < 0 && r[c]) w = c;
            end
            sif.req = r;
            tick(1);
            sif.req = 3'($urandom_range(7, 0));
            checks++;
            if (sif.grant !== 3'(1 << w)) begin
                errors++;
                $display("[TB] FAIL rand_grant%0d: got %b, expected %b", b, sif.grant, 3'(1 << w));
            end
            wait_done(d0, 200, 1'b1, "rand_done");
            checks++;
            if (mon_done[d0] !== 3'(1 << w) || mon_data.size() - b0 != 4) begin
                errors++;
                $display("[TB] FAIL rand_burst%0d: got done %b beats %0d, expected %b 4",
                         b, mon_done[d0], mon_data.size() - b0, 3'(1 << w));
            end else begin
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (int'(mon_data[b0+i]) != accepted_at(dr0, i) || mon_idx[b0+i] != i) begin
                        errors++;
                        $display("[TB] FAIL rand_beat%0d_%0d: got %0d idx %0d, expected %0d idx %0d",
                                 b, i, mon_data[b0+i], mon_idx[b0+i], accepted_at(dr0, i), i);
                    end
                end
            end
            exp_rr = (w + 1) % NUM_REQ;
        end
        sif.req = '0;
        checks++;
        if (int'(sif.reject_cnt) != model_rejects()) begin
            errors++;
            $display("[TB] FAIL rand_rejects: got %0d, expected %0d", sif.reject_cnt, model_rejects());
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        sif.req = '0;
        sif.coeff_ready = 1'b0;
        test_reset();
        test_basic();
        test_reject();
        test_stall();
        test_req_drop();
        test_round_robin();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
